uart_rx_led: RTL and testbench

UART_RX_LED -- requirements
Module: uart_rx_led

---
 rtl/uart_rx_led.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_led.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_led.sv
// UART receiver (8N1) that shows the last good byte on led and a three-byte history on io_led.
// Define UART_RX_PARITY_EN to receive 8E1 frames; this adds the parity_err output.
module uart_rx_led #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  led,
    output logic [23:0] io_led,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic        parity_err
`endif
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $fatal(1, "uart_rx_led: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
`ifdef UART_RX_PARITY_EN
        ,
        StParity
`endif
    } state_t;

    state_t          state;
    logic            sync1;
    logic            sync2;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            commit;
    logic            expired;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
    logic            parity_bad;
`endif

    assign rx_s    = sync2;
    assign expired = (cnt == '0);
`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    assign parity_bad = par_bit != (^shreg);
`endif

    // Synchronizer flops idle at 1 so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            commit    <= 1'b0;
            led       <= 8'hFF;
            io_led    <= 24'hFFFFFF;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            commit    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Outputs update one cycle after the stop-bit sample.
            if (commit) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                led      <= shreg;
                io_led   <= {io_led[15:0], shreg};
            end

            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        cnt   <= HALF_LOAD;
                    end
                end
                StStart: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else if (!rx_s) begin
                        state   <= StData;
                        cnt     <= FULL_LOAD;
                        bit_idx <= '0;
                    end else begin
                        state <= StIdle;
                    end
                end
                StData: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        par_bit <= rx_s;
                        cnt     <= FULL_LOAD;
                        state   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end else begin
`ifdef UART_RX_PARITY_EN
                        parity_err <= parity_bad;
`endif
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            commit <= !parity_bad;
`else
                            commit <= 1'b1;
`endif
                            state  <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StWaitIdle;
                        end
                    end
                end
                StWaitIdle: begin
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_led.sv
// Scoreboard bench for uart_rx_led: stimulus pushes expected pulses, a monitor pops and compares.
module tb_uart_rx_led;

    localparam int unsigned CLK_HZ = 100000000;
    localparam int unsigned BAUD   = 1000000;
    localparam int unsigned BIT_NS = 1000;   // 100 clocks of 10 ns

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  led;
    logic [23:0] io_led;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    uart_rx_led #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .led       (led),
        .io_led    (io_led),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 = good byte, 1 = frame error, 2 = parity error
    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic [23:0] io;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    logic [23:0] io_model = 24'hFFFFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_good(input logic [7:0] b);
        exp_t e;
        io_model = {io_model[15:0], b};
        e.kind = 0;
        e.data = b;
        e.io   = io_model;
        q.push_back(e);
    endtask

    task automatic push_kind(input int k);
        exp_t e;
        e.kind = k;
        e.data = 8'h00;
        e.io   = io_model;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        #(BIT_NS);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        rx = stop_bit;
        #(BIT_NS);
    endtask

    task automatic drain(input string name);
        #(2 * BIT_NS);
        check(name, q.size(), 0);
    endtask

    // Monitor: every output pulse must match the front of the expected queue.
    always @(negedge clk) begin : mon
        exp_t e;
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_parity_err: got pulse expected none");
            end else begin
                e = q.pop_front();
                check("parity_err_kind", e.kind, 2);
            end
        end
`endif
        if (frame_err) begin
            n_ferr++;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame_err: got pulse expected none");
            end else begin
                e = q.pop_front();
                check("frame_err_kind", e.kind, 1);
            end
        end
        if (rx_valid) begin
            n_valid++;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rx_valid: got data %h expected none", rx_data);
            end else begin
                e = q.pop_front();
                check("rx_valid_kind", e.kind, 0);
                check("rx_data", rx_data, e.data);
                check("led", led, e.data);
                check("io_led", io_led, e.io);
            end
        end
    end

    initial begin
        int v0;
        int f0;
        #53;
        check("reset_led", led, 8'hFF);
        check("reset_io_led", io_led, 24'hFFFFFF);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        #(2 * BIT_NS);

        // Single byte
        push_good(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        drain("drain_a5");
        check("a5_io_led", io_led, 24'hFFFFA5);

        // Back-to-back frames with one stop bit
        push_good(8'h01);
        push_good(8'h02);
        push_good(8'h03);
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        drain("drain_b2b");
        check("b2b_io_led", io_led, 24'h010203);
        check("b2b_led", led, 8'h03);
        check("rx_data_hold", rx_data, 8'h03);

        // Bad stop bit, line held low: exactly one frame error
        f0 = n_ferr;
        push_kind(1);
        send_frame(8'h3C, 1'b0, 1'b0);
        #(3 * BIT_NS);
        rx = 1'b1;
        drain("drain_ferr");
        check("ferr_count", n_ferr - f0, 1);
        check("ferr_led_kept", led, 8'h03);
        push_good(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        drain("drain_55");
        check("after_ferr_io_led", io_led, 24'h020355);

        // 200 ns glitch on idle line
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        #200;
        rx = 1'b1;
        #(3 * BIT_NS);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);
        check("glitch_idle", 32'(dut.state), 0);

        // Reset during bit 4 of 0xF0
        v0 = n_valid;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS / 2);
        rst = 1'b1;
        #100;
        check("midreset_led", led, 8'hFF);
        check("midreset_io_led", io_led, 24'hFFFFFF);
        rst = 1'b0;
        io_model = 24'hFFFFFF;
        #(12 * BIT_NS);
        check("midreset_no_valid", n_valid - v0, 0);
        check("midreset_led_after", led, 8'hFF);
        push_good(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        drain("drain_81");
        check("after_reset_io_led", io_led, 24'hFFFF81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: correct even parity bit is 1
        push_kind(2);
        send_frame(8'h07, 1'b1, 1'b1);
        drain("drain_par_bad");
        check("par_bad_led", led, 8'h81);
        push_good(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        drain("drain_par_good");
        check("par_good_led", led, 8'h07);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
